// File: rtl/hex_disp_mux_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hex_disp_mux_if                                            |
// | Description : Bus bundle between a display controller and the           |
// |               hex_disp_mux scanner.                                      |
// |               master : drives data/dp/load/en, observes seg/dp_n/an      |
// |               slave  : the scanner side (consumes data, drives the pads) |
// |   data [4*DIGITS-1:0] hex nibbles, nibble i drives digit i               |
// |   dp   [DIGITS-1:0]   decimal point request per digit, active-high       |
// |   load                strobe that latches data/dp into the scanner       |
// |   en                  display enable, low blanks all anodes              |
// |   seg  [6:0]          segment cathodes, active-low, bit 6 = g            |
// |   dp_n                decimal point cathode, active-low                  |
// |   an   [DIGITS-1:0]   digit anodes, active-low                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface hex_disp_mux_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] data;
  logic [DIGITS-1:0]   dp;
  logic                load;
  logic                en;
  logic [6:0]          seg;
  logic                dp_n;
  logic [DIGITS-1:0]   an;

  modport master (
    output data, dp, load, en,
    input  seg, dp_n, an
  );

  modport slave (
    input  data, dp, load, en,
    output seg, dp_n, an
  );
endinterface
`default_nettype wire

// File: rtl/hex_disp_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hex_disp_mux                                               |
// | Description : Time-multiplexed driver for DIGITS common-anode 7-segment  |
// |               digits. A free-running divider selects each digit for      |
// |               SCAN_DIV clocks; the first clock of every slot is a dead   |
// |               cycle with all anodes off to avoid ghosting.               |
// |   clk   : single clock, rising edge                                      |
// |   rst   : asynchronous, active-high reset                                |
// |   bus   : hex_disp_mux_if.slave (data, dp, load, en in; seg, dp_n, an   |
// |           out; all outputs registered)                                   |
// | Compile-time option: define HEX_DISP_LZ_EN to blank leading zero digits |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module hex_disp_mux #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input wire            clk,
  input wire            rst,
  hex_disp_mux_if.slave bus
);

  // Out-of-range parameters stop elaboration rather than build a broken scanner.
  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("hex_disp_mux: DIGITS=%0d outside 1..8", DIGITS);
  end
  if (SCAN_DIV < 2) begin : g_bad_scan_div
    $error("hex_disp_mux: SCAN_DIV=%0d must be >= 2", SCAN_DIV);
  end

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [6:0]       C_SEG_BLANK = 7'h7F;

  // Active-low segment pattern for one hex nibble, bit order g..a.
  function automatic logic [6:0] seg_enc(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] shadow_data_q, shadow_data_d;
  logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_n_q, dp_n_d;
  logic [DIGITS-1:0]   an_q, an_d;

  logic [DIGITS-1:0]   digit_blank;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_blank;

  // Scan timing: divider and digit index advance regardless of en/load.
  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    idx_d     = idx_q;
    if (div_cnt_q == C_DIV_LAST) begin
      div_cnt_d = '0;
      if (idx_q == C_IDX_LAST) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // Shadow registers decouple the display from a changing source bus.
  always_comb begin
    shadow_data_d = shadow_data_q;
    shadow_dp_d   = shadow_dp_q;
    if (bus.load) begin
      shadow_data_d = bus.data;
      shadow_dp_d   = bus.dp;
    end
  end

`ifdef HEX_DISP_LZ_EN
  // Walk from the most significant digit down; a digit is blanked while
  // every nibble and dp bit from it upward is zero. Digit 0 always shows.
  logic lz_run;
  always_comb begin
    digit_blank = '0;
    lz_run      = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lz_run = lz_run && (shadow_data_q[4*i +: 4] == 4'h0) && !shadow_dp_q[i];
      if (i != 0) begin
        digit_blank[i] = lz_run;
      end
    end
  end
`else
  assign digit_blank = '0;
`endif

  // Pick the fields belonging to the digit currently being scanned.
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib   = shadow_data_q[4*i +: 4];
        cur_dp    = shadow_dp_q[i];
        cur_blank = digit_blank[i];
      end
    end
  end

  // Next output values. The anode stays off during the slot's first cycle
  // (div_cnt = 0) while seg/dp_n already settle on the new digit.
  always_comb begin
    seg_d  = cur_blank ? C_SEG_BLANK : seg_enc(cur_nib);
    dp_n_d = ~cur_dp;
    for (int i = 0; i < DIGITS; i++) begin
      an_d[i] = ~(bus.en && (div_cnt_q != '0) && (idx_q == IDX_W'(i)));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q     <= '0;
      idx_q         <= '0;
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      seg_q         <= C_SEG_BLANK;
      dp_n_q        <= 1'b1;
      an_q          <= '1;
    end else begin
      div_cnt_q     <= div_cnt_d;
      idx_q         <= idx_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      seg_q         <= seg_d;
      dp_n_q        <= dp_n_d;
      an_q          <= an_d;
    end
  end

  assign bus.seg  = seg_q;
  assign bus.dp_n = dp_n_q;
  assign bus.an   = an_q;

endmodule
`default_nettype wire
